// File: rtl/div_infer.sv
// Iterative radix-2 restoring divider with RISC-V M semantics (DIV/DIVU/REM/REMU).
// Each operation runs IDLE -> LOAD -> CALC (WIDTH cycles) -> FIX, and the result appears together with a one-cycle i_done.
module div_infer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    input  logic             is_signed,
    input  logic             rem_sel,
    output logic [WIDTH-1:0] out,
    output logic             i_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             signA_q, signA_d;
    logic             signB_q, signB_d;
    logic             remSel_q, remSel_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             negQuo;
    logic [WIDTH-1:0] quoRes;
    logic [WIDTH-1:0] remRes;

    // The remainder stays below the divisor, so only the trial subtraction needs the extra bit.
    // quo_q holds the raw dividend, then |A|, and finally shifts into the quotient.
    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        div_d    = div_q;
        rem_d    = rem_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        signA_d  = signA_q;
        signB_d  = signB_q;
        remSel_d = remSel_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_q};
        negQuo  = (signA_q ^ signB_q) && (div_q != '0);
        quoRes  = negQuo  ? -quo_q : quo_q;
        remRes  = signA_q ? -rem_q : rem_q;

        unique case (state_q)
            IDLE: begin
                // A start arriving in the i_done cycle is dropped, as if FIX were still active.
                if (start && !done_q) begin
                    quo_d    = inpA;
                    div_d    = inpB;
                    signA_d  = is_signed & inpA[WIDTH-1];
                    signB_d  = is_signed & inpB[WIDTH-1];
                    remSel_d = rem_sel;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                quo_d   = signA_q ? -quo_q : quo_q;
                div_d   = signB_q ? -div_q : div_q;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    busy_d  = 1'b0;
                    state_d = FIX;
                end
            end
            FIX: begin
                out_d   = remSel_q ? remRes : quoRes;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            quo_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            signA_q  <= 1'b0;
            signB_q  <= 1'b0;
            remSel_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            signA_q  <= signA_d;
            signB_q  <= signB_d;
            remSel_q <= remSel_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign out    = out_q;
    assign i_done = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_div_infer.sv
// Directed and randomised checks of div_infer against hand-computed vectors and a RISC-V M reference.
module tb_div_infer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] inpA = '0;
    logic [31:0] inpB = '0;
    logic        is_signed = 1'b0;
    logic        rem_sel = 1'b0;
    logic [31:0] out;
    logic        i_done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    div_infer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .inpA(inpA), .inpB(inpB),
        .is_signed(is_signed), .rem_sel(rem_sel), .out(out), .i_done(i_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        rs;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn, input logic rs);
        logic [31:0] q, r;
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return rs ? r : q;
    endfunction

    // Drive one request, release start after the accepting edge, then scramble the inputs.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic rs);
        @(posedge clk); #1;
        inpA = a; inpB = b; is_signed = sgn; rem_sel = rs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        inpA = $urandom; inpB = $urandom;
        is_signed = 1'($urandom); rem_sel = 1'($urandom);
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic rs, input logic [31:0] exp, input bit disturb);
        int doneAt, doneCnt, busyCnt, both;
        logic [31:0] result;
        applyStimulus(a, b, sgn, rs);
        doneAt = -1; doneCnt = 0; both = 0; result = '0;
        busyCnt = busy ? 1 : 0;
        for (int k = 1; k <= 38; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busyCnt++;
            if (i_done) begin
                doneCnt++;
                if (busy) both++;
                if (doneAt < 0) begin
                    doneAt = k;
                    result = out;
                end
            end
            if (disturb && (k == 4 || k == 32 || k == 33 || k == 34)) start = 1'b1;
        end
        checkOutput({tag, "/value"}, result, exp);
        checkOutput({tag, "/latency"}, doneAt, 34);
        checkOutput({tag, "/doneCount"}, doneCnt, 1);
        checkOutput({tag, "/busyCycles"}, busyCnt, 33);
        checkOutput({tag, "/busyAndDone"}, both, 0);
    endtask

    initial begin
        int doneCnt;
        logic [31:0] a, b;
        logic [31:0] special [4];

        vecs = '{
            '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14},
            '{32'd100,        32'd7,          1'b0, 1'b1, 32'd2},
            '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD},
            '{32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF},
            '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, 32'hFFFF_FFFD},
            '{32'd7,          32'hFFFF_FFFE,  1'b1, 1'b1, 32'd1},
            '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 1'b0, 32'd3},
            '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 1'b1, 32'hFFFF_FFFF},
            '{32'h1234_5678,  32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF},
            '{32'h1234_5678,  32'd0,          1'b1, 1'b1, 32'h1234_5678},
            '{32'h8000_0000,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF},
            '{32'h8000_0000,  32'd0,          1'b1, 1'b1, 32'h8000_0000},
            '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000},
            '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0},
            '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'd0},
            '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000}
        };
        special = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset/out", out, 32'd0);
        checkOutput("reset/done", {31'd0, i_done}, 32'd0);
        checkOutput("reset/busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        checkOutput("resetWinsOverStart", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;

        foreach (vecs[i])
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].rs, vecs[i].exp, 1'b0);

        runOp("startWhileBusy", 32'd1000, 32'd3, 1'b0, 1'b0, 32'd333, 1'b1);

        applyStimulus(32'd1000, 32'd10, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort/busy", {31'd0, busy}, 32'd0);
        checkOutput("abort/out", out, 32'd0);
        checkOutput("abort/done", {31'd0, i_done}, 32'd0);
        doneCnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (i_done) doneCnt++;
        end
        checkOutput("abort/noDone", doneCnt, 0);
        runOp("afterAbort", 32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 1'b0);

        for (int n = 0; n < 150; n++) begin
            logic sgn, rs;
            a = (n % 5 == 0) ? special[$urandom_range(3)] : $urandom;
            b = (n % 3 == 0) ? special[$urandom_range(3)] : $urandom;
            if (n % 7 == 0) b = b >> $urandom_range(31);
            sgn = 1'($urandom);
            rs  = 1'($urandom);
            runOp($sformatf("rand%0d", n), a, b, sgn, rs, refModel(a, b, sgn, rs), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
